// File: rtl/fp_round_pack_pkg.sv
// Shared constants for the FP adder round/pack stage.
// Holds rounding-mode encodings, default widths and the special exponent and result values.
package fpu_pkg;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   localparam int DEFAULT_EXP_W  = 8;
   localparam int DEFAULT_FRAC_W = 23;

   localparam int BIAS = (1 << (DEFAULT_EXP_W - 1)) - 1;

   localparam logic [DEFAULT_EXP_W-1:0] EXP_MAX = {DEFAULT_EXP_W{1'b1}};

   // Largest finite magnitude: exponent one below all-ones, fraction all ones.
   localparam logic [DEFAULT_EXP_W+DEFAULT_FRAC_W:0] MAX_FINITE =
      {1'b0, {(DEFAULT_EXP_W-1){1'b1}}, 1'b0, {DEFAULT_FRAC_W{1'b1}}};

endpackage

// File: rtl/fp_round_pack_if.sv
// Valid/ready bus for the round/pack stage: one upstream beat channel and one downstream result channel.
interface fp_round_pack_if #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
);

   logic                    in_valid;
   logic                    in_ready;
   logic                    in_sign;
   logic [EXP_W-1:0]        in_exp;
   logic [FRAC_W:0]         in_mant;
   logic [2:0]              in_grs;
   logic                    in_zero;
   logic [1:0]              in_rm;
   logic                    out_valid;
   logic                    out_ready;
   logic [EXP_W+FRAC_W:0]   out_result;
   logic                    out_overflow;
   logic                    out_inexact;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_grs, in_zero, in_rm, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_grs, in_zero, in_rm, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_inexact
   );

endinterface

// File: rtl/fp_round_pack_inc.sv
// Round-increment decision: given mode, sign, mantissa LSB and G/R/S, decide whether to add one ULP.
module fp_round_inc
   import fpu_pkg::*;
(
   input  logic [1:0] i_rm,
   input  logic       i_sign,
   input  logic       i_lsb,
   input  logic [2:0] i_grs,
   output logic       o_inc
);

   always_comb begin
      o_inc = 1'b0;
      case (i_rm)
         RM_RNE:  o_inc = i_grs[2] & (i_grs[1] | i_grs[0] | i_lsb);
         RM_RUP:  o_inc = ~i_sign & (|i_grs);
         RM_RDN:  o_inc = i_sign & (|i_grs);
         default: o_inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp_round_pack.sv
// Final FP adder stage: S1 makes the rounding decision and adds it in, S2 renormalises,
// detects overflow and packs the IEEE-754 word. Two registered stages behind valid/ready.
module fp_round_pack
   import fpu_pkg::*;
#(
   parameter int EXP_W  = DEFAULT_EXP_W,
   parameter int FRAC_W = DEFAULT_FRAC_W
) (
   input  logic               clk,
   input  logic               rst,
   fp_round_pack_if.slave     bus
);

   logic                  r_s1Valid;
   logic                  r_s1Sign;
   logic [EXP_W-1:0]      r_s1Exp;
   logic [FRAC_W+1:0]     r_s1Sum;
   logic                  r_s1Zero;
   logic [1:0]            r_s1Rm;
   logic                  r_s1Inexact;
   logic                  r_s1ExpMax;

   logic                  r_outValid;
   logic [EXP_W+FRAC_W:0] r_outResult;
   logic                  r_outOverflow;
   logic                  r_outInexact;

   logic                  w_inc;
   logic [FRAC_W+1:0]     w_sum;
   logic                  w_s2Load;
   logic                  w_inReady;
   logic [EXP_W:0]        w_expR;
   logic [FRAC_W-1:0]     w_frac;
   logic                  w_overflow;
   logic                  w_toInf;
   logic [EXP_W+FRAC_W:0] w_result;
   logic                  w_inexact;

   fp_round_inc u_roundInc (
      .i_rm   (bus.in_rm),
      .i_sign (bus.in_sign),
      .i_lsb  (bus.in_mant[0]),
      .i_grs  (bus.in_grs),
      .o_inc  (w_inc)
   );

   assign w_sum     = {1'b0, bus.in_mant} + {{(FRAC_W+1){1'b0}}, w_inc};
   assign w_s2Load  = ~r_outValid | bus.out_ready;
   assign w_inReady = ~r_s1Valid | w_s2Load;

   // Renormalise on carry-out; a subnormal that rounds into the hidden bit becomes exponent 1.
   always_comb begin
      w_expR = {1'b0, r_s1Exp};
      w_frac = r_s1Sum[FRAC_W-1:0];
      if (r_s1Sum[FRAC_W+1]) begin
         w_frac = '0;
         w_expR = {1'b0, r_s1Exp} + {{EXP_W{1'b0}}, 1'b1};
      end else if ((r_s1Exp == '0) && r_s1Sum[FRAC_W]) begin
         w_expR = {{EXP_W{1'b0}}, 1'b1};
      end
   end

   always_comb begin
      w_overflow = ~r_s1Zero & (r_s1ExpMax | (w_expR >= {1'b0, {EXP_W{1'b1}}}));
      w_toInf    = (r_s1Rm == RM_RNE) ||
                   ((r_s1Rm == RM_RUP) && !r_s1Sign) ||
                   ((r_s1Rm == RM_RDN) && r_s1Sign);
      w_result   = {r_s1Sign, w_expR[EXP_W-1:0], w_frac};
      w_inexact  = r_s1Inexact;
      if (r_s1Zero) begin
         w_result  = {r_s1Sign, {(EXP_W+FRAC_W){1'b0}}};
         w_inexact = 1'b0;
      end else if (w_overflow) begin
         w_inexact = 1'b1;
         if (w_toInf) begin
            w_result = {r_s1Sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         end else begin
            w_result = {r_s1Sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Valid     <= 1'b0;
         r_outValid    <= 1'b0;
         r_outResult   <= '0;
         r_outOverflow <= 1'b0;
         r_outInexact  <= 1'b0;
      end else begin
         if (w_inReady) begin
            r_s1Valid <= bus.in_valid;
         end
         if (w_s2Load) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
               r_outResult   <= w_result;
               r_outOverflow <= w_overflow;
               r_outInexact  <= w_inexact;
            end
         end
      end
   end

   // Payload registers need no reset: r_s1Valid qualifies them.
   always_ff @(posedge clk) begin
      if (w_inReady && bus.in_valid) begin
         r_s1Sign    <= bus.in_sign;
         r_s1Exp     <= bus.in_exp;
         r_s1Sum     <= w_sum;
         r_s1Zero    <= bus.in_zero;
         r_s1Rm      <= bus.in_rm;
         r_s1Inexact <= |bus.in_grs;
         r_s1ExpMax  <= &bus.in_exp;
      end
   end

   assign bus.in_ready     = w_inReady;
   assign bus.out_valid    = r_outValid;
   assign bus.out_result   = r_outResult;
   assign bus.out_overflow = r_outOverflow;
   assign bus.out_inexact  = r_outInexact;

endmodule
